// File: rtl/rv_pkg.sv
// Shared RISC-V register-file types and sizes.
// Used by reg_file_sb and rf_scoreboard.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one bit per architectural register.
// Stall is raised when either source operand is still pending.
module rf_scoreboard
    import rv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             wb_clr,
    input  logic [AW-1:0]    rd_addr,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [NREGS-1:0] pending,
    output logic             stall
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // An issue outranks a same-cycle clear so a re-issued destination is never lost.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < NREGS; i++) begin
            if (issue_valid && issue_rd == reg_addr_t'(i)) begin
                pending_d[i] = 1'b1;
            end else if (wb_clr && rd_addr == reg_addr_t'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    assign stall = (pending_q[rs1_addr] && rs1_addr != REG_ZERO) ||
                   (pending_q[rs2_addr] && rs2_addr != REG_ZERO);

endmodule

// File: rtl/reg_file_sb.sv
// 32-entry integer register file, two registered read ports, one write port,
// with embedded scoreboard. Define RF_WRITE_BYPASS_EN for write-first reads.
module reg_file_sb
    import rv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             we,
    input  logic [AW-1:0]    rd_addr,
    input  logic [XLEN-1:0]  wd,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             wb_clr,
    output logic             stall,
    output logic [NREGS-1:0] pending
);

    xword_t regs_q [NREGS];
    xword_t rs1_q, rs1_d;
    xword_t rs2_q, rs2_d;
    logic   wr_en;

    assign wr_en = we && (rd_addr != REG_ZERO);

    always_comb begin
        rs1_d = regs_q[rs1_addr];
        rs2_d = regs_q[rs2_addr];
`ifdef RF_WRITE_BYPASS_EN
        if (wr_en && rd_addr == rs1_addr) rs1_d = wd;
        if (wr_en && rd_addr == rs2_addr) rs2_d = wd;
`endif
        // x0 reads as zero regardless of storage or bypass.
        if (rs1_addr == REG_ZERO) rs1_d = '0;
        if (rs2_addr == REG_ZERO) rs2_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[rd_addr] <= wd;
            end
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end

    assign rs1_data = rs1_q;
    assign rs2_data = rs2_q;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_clr      (wb_clr),
        .rd_addr     (rd_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .pending     (pending),
        .stall       (stall)
    );

endmodule
